// File: rtl/intlv_pkg.sv
// ---------------------------------------------------------------------------
// intlv_pkg
// Shared definitions for the turbo interleaver RAM controller:
//   - legal link block lengths and the base address of each link region
//   - FSM state encoding
//   - is_legal_len(): true when a block length is one of the six links
// ---------------------------------------------------------------------------
package intlv_pkg;

    localparam int LEN_W = 13;

    // Block length of each supported link
    localparam logic [LEN_W-1:0] LEN_ID5  = 13'd288;
    localparam logic [LEN_W-1:0] LEN_ID6  = 13'd672;
    localparam logic [LEN_W-1:0] LEN_ID7  = 13'd1056;
    localparam logic [LEN_W-1:0] LEN_ID11 = 13'd432;
    localparam logic [LEN_W-1:0] LEN_ID17 = 13'd1872;
    localparam logic [LEN_W-1:0] LEN_ID19 = 13'd5616;

    // Regions are packed back to back in the order listed above
    localparam logic [15:0] BASE_ID5  = 16'h0000;
    localparam logic [15:0] BASE_ID6  = 16'h0120;
    localparam logic [15:0] BASE_ID7  = 16'h03C0;
    localparam logic [15:0] BASE_ID11 = 16'h07E0;
    localparam logic [15:0] BASE_ID17 = 16'h0990;
    localparam logic [15:0] BASE_ID19 = 16'h10E0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    function automatic logic is_legal_len(input logic [LEN_W-1:0] len);
        return (len == LEN_ID5)  || (len == LEN_ID6)  || (len == LEN_ID7) ||
               (len == LEN_ID11) || (len == LEN_ID17) || (len == LEN_ID19);
    endfunction

endpackage

// File: rtl/intlv_ram_ctrl_if.sv
// ---------------------------------------------------------------------------
// intlv_ram_ctrl_if
// Bus between the address generator / sample source / output sink and the
// interleaver RAM controller.
//   din, din_vld, m_len     : incoming code bits and block length
//   wen, enable, id_jump    : write strobe and address from the generator
//   request                 : read-step pulse back to the generator
//   dout, dout_vld, dout_rdy: output stream handshake
//   done, busy, err         : status
// Modports: master = environment side, slave = controller side.
// ---------------------------------------------------------------------------
interface intlv_ram_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16
);
    logic [DATA_W-1:0]           din;
    logic                        din_vld;
    logic [intlv_pkg::LEN_W-1:0] m_len;
    logic                        wen;
    logic [ADDR_W-1:0]           enable;
    logic [ADDR_W-1:0]           id_jump;
    logic                        request;
    logic [DATA_W-1:0]           dout;
    logic                        dout_vld;
    logic                        dout_rdy;
    logic                        done;
    logic                        busy;
    logic                        err;

    modport master (
        output din, din_vld, m_len, wen, enable, id_jump, dout_rdy,
        input  request, dout, dout_vld, done, busy, err
    );

    modport slave (
        input  din, din_vld, m_len, wen, enable, id_jump, dout_rdy,
        output request, dout, dout_vld, done, busy, err
    );
endinterface

// File: rtl/intlv_sp_ram.sv
// ---------------------------------------------------------------------------
// intlv_sp_ram
// Single-port synchronous RAM, read-first, one cycle read latency.
//   clk   : clock
//   we    : write enable
//   addr  : word address
//   wdata : write data
//   rdata : read data, registered (valid the cycle after addr)
// ---------------------------------------------------------------------------
module intlv_sp_ram #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 9936,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset so it maps onto block RAM; every location
    // is written before it is read back, so its power-up contents never leak.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end
endmodule

// File: rtl/intlv_ram_ctrl.sv
// ---------------------------------------------------------------------------
// intlv_ram_ctrl
// Stores one interleaver block at id_jump + enable as the address generator
// strobes wen, then steps the generator with request pulses, reads the block
// back and streams it through a small output FIFO.
//   clk   : clock
//   n_rst : asynchronous reset, active low
//   bus   : intlv_ram_ctrl_if slave (sample input, generator address,
//           request, output stream, done/busy/err status)
// ---------------------------------------------------------------------------
module intlv_ram_ctrl
    import intlv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 9936,
    parameter int FIFO_D = 4
) (
    input  logic            clk,
    input  logic            n_rst,
    intlv_ram_ctrl_if.slave bus
);
    localparam int RAM_AW = $clog2(DEPTH);
    localparam int PTR_W  = $clog2(FIFO_D);
    localparam int CNT_W  = $clog2(FIFO_D + 1);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    localparam logic [CNT_W:0]    CREDIT  = (CNT_W + 1)'(FIFO_D);

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic [LEN_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic               hold_q, hold_d;     // illegal length seen, wait for din_vld low
    logic               err_q, err_d;
    logic               done_q, done_d;
    logic               inflight_q;         // a RAM read was issued last cycle
    logic               rd_oob_q;           // ... and its address was out of range
    logic [DATA_W-1:0]  din_d_q;

    logic [PTR_W-1:0]              wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]              fifo_cnt_q;
    logic [FIFO_D-1:0][DATA_W-1:0] fifo_mem_q;

    logic [ADDR_W-1:0]  addr;
    logic               addr_oob;
    logic               ram_we;
    logic [DATA_W-1:0]  ram_rdata;
    logic               req;
    logic [CNT_W:0]     outstanding;
    logic               push, pop;
    logic [DATA_W-1:0]  push_data;

    // 16-bit add, carry out discarded
    assign addr     = bus.id_jump + bus.enable;
    assign addr_oob = (addr >= DEPTH_A);

    // Reads in flight plus words already queued may never exceed the FIFO
    // depth, which is what makes an unconditional push safe.
    assign outstanding = {1'b0, fifo_cnt_q} + {{CNT_W{1'b0}}, inflight_q};

    intlv_sp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (addr[RAM_AW-1:0]),
        .wdata (din_d_q),
        .rdata (ram_rdata)
    );

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        hold_d   = hold_q;
        err_d    = err_q;
        done_d   = 1'b0;
        ram_we   = 1'b0;
        req      = 1'b0;

        if (hold_q && !bus.din_vld) begin
            hold_d = 1'b0;
        end
        if (bus.wen && (state_q != ST_WRITE)) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (bus.din_vld && !hold_q) begin
                    len_d    = bus.m_len;
                    wr_cnt_d = '0;
                    rd_cnt_d = '0;
                    if (is_legal_len(bus.m_len)) begin
                        state_d = ST_WRITE;
                    end else begin
                        err_d  = 1'b1;
                        hold_d = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                if (bus.wen) begin
                    // An out-of-range write is dropped but still counted so
                    // the block length stays in step with the generator.
                    wr_cnt_d = wr_cnt_q + 1'b1;
                    if (addr_oob) begin
                        err_d = 1'b1;
                    end else begin
                        ram_we = 1'b1;
                    end
                    if (wr_cnt_d == len_q) begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if ((rd_cnt_q < len_q) && (outstanding < CREDIT)) begin
                    req      = 1'b1;
                    rd_cnt_d = rd_cnt_q + 1'b1;
                    if (addr_oob) begin
                        err_d = 1'b1;
                    end
                end else if ((rd_cnt_q == len_q) && !inflight_q) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_cnt_q == '0) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            hold_q     <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            inflight_q <= 1'b0;
            rd_oob_q   <= 1'b0;
            din_d_q    <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            hold_q     <= hold_d;
            err_q      <= err_d;
            done_q     <= done_d;
            inflight_q <= req;
            rd_oob_q   <= req & addr_oob;
            din_d_q    <= bus.din;  // lines din up with the generator's wen
        end
    end

    // Output FIFO: read data is pushed the cycle after its request
    assign push      = inflight_q;
    assign push_data = rd_oob_q ? '0 : ram_rdata;
    assign pop       = (fifo_cnt_q != '0) && bus.dout_rdy;

    // Storage is only FIFO_D words, so it is cleared to give dout a defined
    // zero out of reset. FIFO_D is a power of two; pointers wrap naturally.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            fifo_mem_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) begin
                fifo_mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q             <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    assign bus.request  = req;
    assign bus.dout     = fifo_mem_q[rd_ptr_q];
    assign bus.dout_vld = (fifo_cnt_q != '0);
    assign bus.done     = done_q;
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.err      = err_q;

endmodule

// File: tb/tb_intlv_ram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_intlv_ram_ctrl
// Drives interleaved blocks into intlv_ram_ctrl, acting as the address
// generator, and compares the output stream with a model memory: sample i of
// a block lands at base + ord[i]; readback walks offsets 0..N-1 in order.
// ---------------------------------------------------------------------------
module tb_intlv_ram_ctrl;
    import intlv_pkg::*;

    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 16;
    localparam int DEPTH   = 9936;
    localparam int FIFO_D  = 4;
    localparam int MAX_LEN = 5616;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    intlv_ram_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    intlv_ram_ctrl #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .FIFO_D (FIFO_D)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model
    logic [DATA_W-1:0] model_mem [DEPTH];
    logic [DATA_W-1:0] blk_data [MAX_LEN];
    int                blk_ord  [MAX_LEN];
    logic [DATA_W-1:0] exp_q [$];
    logic              exp_err;

    // Per-block observations gathered by the monitor
    int   cyc = 0;
    int   blk_len, blk_reqs, blk_pops, blk_dones;
    int   first_req_cyc, first_vld_cyc, done_cyc;
    bit   req_s;
    logic prev_stall;
    logic [DATA_W-1:0] prev_dout;

    always @(negedge clk) begin
        cyc++;
        if (!n_rst) begin
            req_s      = 1'b0;
            prev_stall = 1'b0;
        end else begin
            req_s = bus.request;
            if (bus.request) begin
                check("credit", 32'((blk_reqs - blk_pops) < FIFO_D), 1);
                check("req_in_block", 32'(blk_reqs < blk_len), 1);
                if (blk_reqs == 0) first_req_cyc = cyc;
                blk_reqs++;
            end
            if (prev_stall && bus.dout_vld) check("dout_hold", bus.dout, prev_dout);
            if (bus.dout_vld) begin
                if (first_vld_cyc < 0) first_vld_cyc = cyc;
                if (bus.dout_rdy) begin
                    if (exp_q.size() == 0) check("extra_output", bus.dout_vld, 0);
                    else check("dout", bus.dout, exp_q.pop_front());
                    blk_pops++;
                end
            end
            prev_stall = bus.dout_vld && !bus.dout_rdy;
            prev_dout  = bus.dout;
            if (bus.done) begin
                blk_dones++;
                done_cyc = cyc;
            end
        end
    end

    // mode 0: always ready, 1: random, 2: never ready
    function automatic logic rdy_val(input int mode);
        if (mode == 0) return 1'b1;
        if (mode == 1) return 1'($urandom_range(1, 0));
        return 1'b0;
    endfunction

    // Sample i is presented with din_vld in cycle i and its wen/enable
    // follow one cycle later, as the generator does.
    task automatic drive_block(input int len, input logic [15:0] base);
        @(posedge clk); #1;
        for (int i = 0; i <= len; i++) begin
            bus.din_vld = (i < len);
            bus.din     = (i < len) ? blk_data[i] : '0;
            bus.m_len   = 13'(len);
            bus.id_jump = base;
            bus.wen     = (i > 0);
            bus.enable  = (i > 0) ? 16'(blk_ord[i-1]) : 16'd0;
            @(posedge clk); #1;
        end
        bus.din_vld = 1'b0;
        bus.wen     = 1'b0;
        bus.enable  = 16'd0;
    endtask

    task automatic run_block(input string name, input int len, input logic [15:0] base,
                             input bit ramp, input bit shuffle, input int rdy_m,
                             input bit stall, input int stop_after);
        int mode;
        for (int i = 0; i < len; i++) begin
            blk_data[i] = ramp ? 8'(i) : 8'($urandom);
            blk_ord[i]  = i;
        end
        if (shuffle) begin
            for (int i = len - 1; i > 0; i--) begin
                int j, tmp;
                j          = $urandom_range(i, 0);
                tmp        = blk_ord[i];
                blk_ord[i] = blk_ord[j];
                blk_ord[j] = tmp;
            end
        end
        for (int i = 0; i < len; i++) model_mem[int'(base) + blk_ord[i]] = blk_data[i];
        exp_q.delete();
        for (int i = 0; i < len; i++) exp_q.push_back(model_mem[int'(base) + i]);

        blk_len       = len;
        blk_reqs      = 0;
        blk_pops      = 0;
        blk_dones     = 0;
        first_req_cyc = -1;
        first_vld_cyc = -1;
        done_cyc      = -1;
        mode          = stall ? 2 : rdy_m;
        bus.dout_rdy  = rdy_val(mode);

        drive_block(len, base);
        check({name, "_busy_read"}, 32'(bus.busy), 1);

        for (int t = 0; t < 20 * len + 200; t++) begin
            @(posedge clk); #1;
            if (req_s) bus.enable = bus.enable + 16'd1;  // generator steps on request
            bus.dout_rdy = rdy_val(mode);
            if (stall && t == 20) begin
                check("stall_reqs", blk_reqs, FIFO_D);
                check("stall_vld", 32'(bus.dout_vld), 1);
                check("stall_dout", bus.dout, exp_q[0]);
                mode = rdy_m;
            end
            if (stop_after > 0 && blk_pops >= stop_after) return;
            if (blk_dones > 0) break;
        end
        repeat (2) @(posedge clk);
        #1;
        check({name, "_done"}, blk_dones, 1);
        check({name, "_pops"}, blk_pops, len);
        check({name, "_reqs"}, blk_reqs, len);
        check({name, "_left"}, exp_q.size(), 0);
        check({name, "_idle"}, 32'(bus.busy), 0);
        check({name, "_err"}, 32'(bus.err), 32'(exp_err));
        if (rdy_m == 0 && !stall) begin
            check({name, "_first_vld_lat"}, first_vld_cyc - first_req_cyc, 2);
            check({name, "_done_lat"}, done_cyc - first_req_cyc, len + 3);
        end
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
        $fatal(1);
    end

    initial begin : main
        n_rst        = 1'b1;
        bus.din      = '0;
        bus.din_vld  = 1'b0;
        bus.m_len    = '0;
        bus.wen      = 1'b0;
        bus.enable   = '0;
        bus.id_jump  = '0;
        bus.dout_rdy = 1'b0;
        exp_err      = 1'b0;
        blk_len      = 0;
        blk_reqs     = 0;
        blk_pops     = 0;
        blk_dones    = 0;

        #2 n_rst = 1'b0;
        #1;
        check("rst_request", 32'(bus.request), 0);
        check("rst_dout", bus.dout, 0);
        check("rst_dout_vld", 32'(bus.dout_vld), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_err", 32'(bus.err), 0);
        repeat (3) @(posedge clk);
        #1 n_rst = 1'b1;

        // Ramp in order, always ready: exact latency checks
        run_block("l5", int'(LEN_ID5), BASE_ID5, 1'b1, 1'b0, 0, 1'b0, 0);
        // Largest block, interleaved, random backpressure
        run_block("l19", int'(LEN_ID19), BASE_ID19, 1'b0, 1'b1, 1, 1'b0, 0);
        // Back-to-back blocks in adjacent and distant regions
        run_block("l6", int'(LEN_ID6), BASE_ID6, 1'b0, 1'b1, 0, 1'b0, 0);
        run_block("l11", int'(LEN_ID11), BASE_ID11, 1'b0, 1'b1, 0, 1'b0, 0);
        // Output stalled at the start of the read phase, then released
        run_block("l17", int'(LEN_ID17), BASE_ID17, 1'b0, 1'b1, 0, 1'b1, 0);

        // Illegal block length
        blk_len  = 0;
        blk_reqs = 0;
        @(posedge clk); #1;
        bus.m_len   = 13'h100;
        bus.din_vld = 1'b1;
        bus.din     = 8'hA5;
        bus.id_jump = BASE_ID6;
        bus.enable  = 16'd0;
        bus.wen     = 1'b0;
        @(posedge clk); #1;
        check("illegal_err", 32'(bus.err), 1);
        check("illegal_busy", 32'(bus.busy), 0);
        exp_err = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.wen    = 1'b1;
            bus.enable = 16'(k);
            @(posedge clk); #1;
            check("illegal_busy_hold", 32'(bus.busy), 0);
        end
        bus.wen     = 1'b0;
        bus.din_vld = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("illegal_reqs", blk_reqs, 0);

        // Reset in the middle of a read phase
        run_block("l11_rst", int'(LEN_ID11), BASE_ID11, 1'b0, 1'b1, 1, 1'b0, 100);
        check("rst_mid_pops", 32'(blk_pops >= 100), 1);
        #2 n_rst = 1'b0;
        #1;
        check("rst_mid_request", 32'(bus.request), 0);
        check("rst_mid_dout", bus.dout, 0);
        check("rst_mid_dout_vld", 32'(bus.dout_vld), 0);
        check("rst_mid_done", 32'(bus.done), 0);
        check("rst_mid_busy", 32'(bus.busy), 0);
        check("rst_mid_err", 32'(bus.err), 0);
        bus.enable   = 16'd0;
        bus.din_vld  = 1'b0;
        bus.wen      = 1'b0;
        bus.dout_rdy = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;
        exp_err = 1'b0;
        run_block("l7", int'(LEN_ID7), BASE_ID7, 1'b0, 1'b1, 0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
